vga_layer_mixer: RTL and testbench



---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_delay.sv | 25 ++
 rtl/vga_layer_mixer.sv | 137 +++++++++++++
 tb/tb_vga_layer_mixer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA display path (1024x768 @ 60 Hz, 65 MHz pixel clock).
// Optional shot flash: VGA_MIXER_FLASH_EN.
package vga_pkg;

  localparam int HC_W  = 11;
  localparam int RGB_W = 12;

  // 1024x768 timing shared with vga_timing
  localparam int H_VISIBLE = 1024;
  localparam int H_FRONT   = 24;
  localparam int H_SYNC    = 136;
  localparam int H_BACK    = 160;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_VISIBLE = 768;
  localparam int V_FRONT   = 3;
  localparam int V_SYNC    = 6;
  localparam int V_BACK    = 29;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [RGB_W-1:0] FLASH_RGB_DEFAULT = 12'hFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FLASH = 2'd2
  } flash_state_e;

endpackage

// File: rtl/vga_delay.sv
// Parametrised width/depth shift register with synchronous active-high reset.
module vga_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/vga_layer_mixer.sv
// Fixed-priority N-layer pixel mixer with frame-synchronous enables and 2-cycle matched timing.
// Optional shot flash FSM built when VGA_MIXER_FLASH_EN is defined.
module vga_layer_mixer #(
  parameter int                   N_LAYERS     = 4,
  parameter int                   RGB_W        = 12,
  parameter int                   HC_W         = 11,
  parameter int                   FLASH_FRAMES = 3,
  parameter logic [RGB_W-1:0]     FLASH_RGB    = 12'hFFF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        new_frame,
  input  logic [HC_W-1:0]             hcount_i,
  input  logic [HC_W-1:0]             vcount_i,
  input  logic                        hsync_i,
  input  logic                        vsync_i,
  input  logic                        hblnk_i,
  input  logic                        vblnk_i,
  input  logic [N_LAYERS*RGB_W-1:0]   layer_rgb_i,
  input  logic [N_LAYERS-1:0]         layer_opaque_i,
  input  logic [N_LAYERS-1:0]         layer_en_i,
  input  logic                        flash_req,
  output logic [HC_W-1:0]             hcount_o,
  output logic [HC_W-1:0]             vcount_o,
  output logic                        hsync_o,
  output logic                        vsync_o,
  output logic                        hblnk_o,
  output logic                        vblnk_o,
  output logic [RGB_W-1:0]            rgb_o,
  output logic [N_LAYERS-1:0]         en_active_o
);

  import vga_pkg::*;

  localparam int TIM_W = 2*HC_W + 4;

  logic [TIM_W-1:0]          w_timIn;
  logic [TIM_W-1:0]          w_timS1;
  logic [TIM_W-1:0]          w_timS2;
  logic [N_LAYERS*RGB_W-1:0] r_layerRgb;
  logic [N_LAYERS-1:0]       r_layerOpaque;
  logic [N_LAYERS-1:0]       r_enActive;
  logic [RGB_W-1:0]          w_selPix;
  logic                      w_blankS1;
  logic                      w_flash;
  logic [RGB_W-1:0]          r_rgb;

  assign w_timIn = {hcount_i, vcount_i, hsync_i, vsync_i, hblnk_i, vblnk_i};

  vga_delay #(.WIDTH(TIM_W), .DEPTH(1)) u_delayS1 (
    .clk    (clk),
    .rst    (rst),
    .i_data (w_timIn),
    .o_data (w_timS1)
  );

  vga_delay #(.WIDTH(TIM_W), .DEPTH(1)) u_delayS2 (
    .clk    (clk),
    .rst    (rst),
    .i_data (w_timS1),
    .o_data (w_timS2)
  );

  // Enables load together with pixel (0,0), so the whole new frame sees them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_layerRgb    <= '0;
      r_layerOpaque <= '0;
      r_enActive    <= '1;
    end else begin
      r_layerRgb    <= layer_rgb_i;
      r_layerOpaque <= layer_opaque_i;
      if (new_frame) r_enActive <= layer_en_i;
    end
  end

  always_comb begin
    w_selPix = '0;
    for (int k = N_LAYERS-1; k >= 0; k--) begin
      if (r_layerOpaque[k] && r_enActive[k]) w_selPix = r_layerRgb[k*RGB_W +: RGB_W];
    end
  end

  assign w_blankS1 = w_timS1[1] | w_timS1[0];

`ifdef VGA_MIXER_FLASH_EN
  localparam int CNT_W = $clog2(FLASH_FRAMES+1);

  flash_state_e      r_flashState;
  logic [CNT_W-1:0]  r_frameCnt;

  // Requests are only accepted from IDLE; state changes on new_frame align with pixel (0,0)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flashState <= ST_IDLE;
      r_frameCnt   <= '0;
    end else begin
      case (r_flashState)
        ST_IDLE: begin
          if (flash_req) r_flashState <= ST_ARMED;
        end
        ST_ARMED: begin
          if (new_frame) begin
            r_flashState <= ST_FLASH;
            r_frameCnt   <= '0;
          end
        end
        ST_FLASH: begin
          if (new_frame) begin
            if (r_frameCnt == CNT_W'(FLASH_FRAMES-1)) r_flashState <= ST_IDLE;
            else r_frameCnt <= r_frameCnt + 1'b1;
          end
        end
        default: r_flashState <= ST_IDLE;
      endcase
    end
  end

  assign w_flash = (r_flashState == ST_FLASH);
`else
  logic w_unused_flash;
  assign w_unused_flash = flash_req ^ (^FLASH_RGB) ^ (FLASH_FRAMES == 0);
  assign w_flash        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)            r_rgb <= '0;
    else if (w_blankS1) r_rgb <= '0;
    else if (w_flash)   r_rgb <= FLASH_RGB;
    else                r_rgb <= w_selPix;
  end

  assign {hcount_o, vcount_o, hsync_o, vsync_o, hblnk_o, vblnk_o} = w_timS2;
  assign rgb_o       = r_rgb;
  assign en_active_o = r_enActive;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Self-checking bench for vga_layer_mixer using a shrunken raster and a frame-level reference model.
// Flash expectations follow VGA_MIXER_FLASH_EN.
module tb_vga_layer_mixer;

  localparam int NL = 4;
  localparam int RW = 12;
  localparam int HW = 11;
  localparam int FLASH_N = 3;
  localparam int H_TOT = 32, H_VIS = 20, V_TOT = 10, V_VIS = 6;
`ifdef VGA_MIXER_FLASH_EN
  localparam bit FLASH_BUILT = 1'b1;
`else
  localparam bit FLASH_BUILT = 1'b0;
`endif

  typedef struct {
    logic [HW-1:0] hc;
    logic [HW-1:0] vc;
    logic hs, vs, hb, vb;
    logic [RW-1:0] rgb;
  } outRec_t;

  logic clk = 1'b0;
  logic rst, new_frame, hsync_i, vsync_i, hblnk_i, vblnk_i, flash_req;
  logic [HW-1:0] hcount_i, vcount_i, hcount_o, vcount_o;
  logic hsync_o, vsync_o, hblnk_o, vblnk_o;
  logic [NL*RW-1:0] layer_rgb_i;
  logic [NL-1:0] layer_opaque_i, layer_en_i, en_active_o;
  logic [RW-1:0] rgb_o;

  int checks = 0;
  int fails = 0;
  outRec_t q[$];
  outRec_t ex;
  bit exValid;
  logic [NL-1:0] enModel;
  bit armed;
  int flashLeft;
  int h = 0, v = 0;

  vga_layer_mixer dut (
    .clk(clk), .rst(rst), .new_frame(new_frame),
    .hcount_i(hcount_i), .vcount_i(vcount_i),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .hblnk_i(hblnk_i), .vblnk_i(vblnk_i),
    .layer_rgb_i(layer_rgb_i), .layer_opaque_i(layer_opaque_i), .layer_en_i(layer_en_i),
    .flash_req(flash_req),
    .hcount_o(hcount_o), .vcount_o(vcount_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .hblnk_o(hblnk_o), .vblnk_o(vblnk_o),
    .rgb_o(rgb_o), .en_active_o(en_active_o)
  );

  always #5 clk = ~clk;

  // Highest-priority visible layer: first index that is both opaque and enabled
  function automatic logic [RW-1:0] topPixel(logic [NL*RW-1:0] rgbs, logic [NL-1:0] opq, logic [NL-1:0] en);
    for (int k = 0; k < NL; k++) if (opq[k] && en[k]) return rgbs[k*RW +: RW];
    return '0;
  endfunction

  // Drives one raster position, updates the model, advances a clock and exposes the record due now
  task automatic applyStimulus();
    outRec_t e;
    bit idleBefore;
    hcount_i  = HW'(h);
    vcount_i  = HW'(v);
    hsync_i   = (h >= 24 && h < 28);
    vsync_i   = (v == 7);
    hblnk_i   = (h >= H_VIS);
    vblnk_i   = (v >= V_VIS);
    new_frame = (h == 0 && v == 0);
    if (rst) begin
      q.delete();
      e = '{hc: '0, vc: '0, hs: 1'b0, vs: 1'b0, hb: 1'b0, vb: 1'b0, rgb: '0};
      q.push_back(e);
      enModel = '1;
      armed = 1'b0;
      flashLeft = 0;
    end else begin
      idleBefore = !armed && flashLeft == 0;
      if (new_frame) begin
        enModel = layer_en_i;
        if (armed) begin
          armed = 1'b0;
          flashLeft = FLASH_N;
        end else if (flashLeft > 0) begin
          flashLeft--;
        end
      end
      if (FLASH_BUILT && idleBefore && flash_req) armed = 1'b1;
      e.hc = hcount_i; e.vc = vcount_i;
      e.hs = hsync_i;  e.vs = vsync_i; e.hb = hblnk_i; e.vb = vblnk_i;
      if (hblnk_i || vblnk_i) e.rgb = '0;
      else if (flashLeft > 0) e.rgb = 12'hFFF;
      else e.rgb = topPixel(layer_rgb_i, layer_opaque_i, enModel);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    exValid = (q.size() >= 2);
    if (exValid) ex = q.pop_front();
    if (h == H_TOT-1) begin
      h = 0;
      v = (v == V_TOT-1) ? 0 : v + 1;
    end else begin
      h++;
    end
  endtask

  task automatic runTo(int hh, int vv);
    for (int n = 0; n < H_TOT*V_TOT && !(h == hh && v == vv); n++) applyStimulus();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus();
    checks++;
    if ({hcount_o, vcount_o, hsync_o, vsync_o, hblnk_o, vblnk_o, rgb_o} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got h=%0d v=%0d sync=%b%b blnk=%b%b rgb=%h, expected all 0",
               hcount_o, vcount_o, hsync_o, vsync_o, hblnk_o, vblnk_o, rgb_o);
    end
    checks++;
    if (en_active_o !== 4'hF) begin
      fails++;
      $display("[TB] FAIL reset_en_active: got %b expected 1111", en_active_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_delay();
    layer_opaque_i = '0;
    for (int n = 0; n < 2*H_TOT*V_TOT; n++) begin
      layer_rgb_i = {$urandom, $urandom};
      layer_en_i  = NL'($urandom);
      applyStimulus();
      if (exValid) begin
        checks++;
        if ({hcount_o, vcount_o, hsync_o, vsync_o, hblnk_o, vblnk_o} !== {ex.hc, ex.vc, ex.hs, ex.vs, ex.hb, ex.vb}) begin
          fails++;
          $display("[TB] FAIL delay_timing: got h=%0d v=%0d flags=%b%b%b%b expected h=%0d v=%0d flags=%b%b%b%b",
                   hcount_o, vcount_o, hsync_o, vsync_o, hblnk_o, vblnk_o, ex.hc, ex.vc, ex.hs, ex.vs, ex.hb, ex.vb);
        end
        checks++;
        if (rgb_o !== 12'h000) begin
          fails++;
          $display("[TB] FAIL delay_transparent_rgb: got %h expected 000", rgb_o);
        end
      end
    end
  endtask

  task automatic test_priority();
    layer_en_i = '1;
    runTo(0, 0);
    layer_rgb_i = {12'h00F, 12'h0A0, 12'h050, 12'hF00};
    layer_opaque_i = 4'b1001;
    runTo(5, 2);
    for (int n = 0; n < 6; n++) begin
      applyStimulus();
      checks++;
      if (n >= 2 && rgb_o !== 12'hF00) begin
        fails++;
        $display("[TB] FAIL priority_layer0: got %h expected F00", rgb_o);
      end
    end
    layer_opaque_i = 4'b1000;
    for (int n = 0; n < 6; n++) begin
      applyStimulus();
      checks++;
      if (rgb_o !== ((n < 1) ? 12'hF00 : 12'h00F)) begin
        fails++;
        $display("[TB] FAIL priority_background: cycle %0d got %h expected %h", n, rgb_o, (n < 1) ? 12'hF00 : 12'h00F);
      end
    end
  endtask

  task automatic test_blank();
    layer_opaque_i = '1;
    layer_rgb_i = {12'h123, 12'h456, 12'h789, 12'hABC};
    for (int n = 0; n < H_TOT*V_TOT; n++) begin
      applyStimulus();
      if (exValid && (ex.hb || ex.vb)) begin
        checks++;
        if (rgb_o !== 12'h000) begin
          fails++;
          $display("[TB] FAIL blank_rgb: at h=%0d v=%0d got %h expected 000", ex.hc, ex.vc, rgb_o);
        end
      end
    end
  endtask

  task automatic test_random_mix();
    for (int n = 0; n < 2*H_TOT*V_TOT; n++) begin
      layer_rgb_i    = {$urandom, $urandom};
      layer_opaque_i = NL'($urandom);
      layer_en_i     = NL'($urandom);
      applyStimulus();
      if (exValid) begin
        checks++;
        if (rgb_o !== ex.rgb) begin
          fails++;
          $display("[TB] FAIL random_mix: at h=%0d v=%0d got %h expected %h", ex.hc, ex.vc, rgb_o, ex.rgb);
        end
        checks++;
        if (en_active_o !== enModel) begin
          fails++;
          $display("[TB] FAIL random_en_active: got %b expected %b", en_active_o, enModel);
        end
      end
    end
  endtask

  task automatic test_shadow();
    layer_en_i = '1;
    layer_rgb_i = {12'h00F, 12'h111, 12'h222, 12'h0F0};
    layer_opaque_i = 4'b1001;
    runTo(0, 0);
    runTo(7, 3);
    layer_en_i = 4'b1110;
    while (!(h == 0 && v == 0)) begin
      applyStimulus();
      checks++;
      if (en_active_o[0] !== 1'b1 || (exValid && rgb_o !== ex.rgb)) begin
        fails++;
        $display("[TB] FAIL shadow_hold: got en=%b rgb=%h expected en[0]=1 rgb=%h", en_active_o, rgb_o, ex.rgb);
      end
    end
    applyStimulus();
    checks++;
    if (en_active_o !== 4'b1110) begin
      fails++;
      $display("[TB] FAIL shadow_load: got %b expected 1110", en_active_o);
    end
    applyStimulus();
    applyStimulus();
    checks++;
    if (rgb_o !== 12'h00F) begin
      fails++;
      $display("[TB] FAIL shadow_pixel00: got %h expected 00F", rgb_o);
    end
  endtask

  task automatic test_flash();
    int whites;
    whites = 0;
    layer_en_i = '1;
    runTo(0, 0);
    runTo(4, 3);
    flash_req = 1'b1;
    applyStimulus();
    flash_req = 1'b0;
    for (int n = 0; n < 4*H_TOT*V_TOT + H_TOT*(V_TOT-3) + 4; n++) begin
      layer_rgb_i    = {$urandom, $urandom} & {NL{12'h7FF}};
      layer_opaque_i = NL'($urandom);
      flash_req      = (n == H_TOT*V_TOT + H_TOT*(V_TOT-3) + 40);
      applyStimulus();
      if (exValid) begin
        checks++;
        if (rgb_o !== ex.rgb) begin
          fails++;
          $display("[TB] FAIL flash_pixel: at h=%0d v=%0d got %h expected %h", ex.hc, ex.vc, rgb_o, ex.rgb);
        end
        if (rgb_o === 12'hFFF) whites++;
      end
    end
    flash_req = 1'b0;
    checks++;
    if (whites !== (FLASH_BUILT ? FLASH_N*H_VIS*V_VIS : 0)) begin
      fails++;
      $display("[TB] FAIL flash_white_count: got %0d expected %0d", whites, FLASH_BUILT ? FLASH_N*H_VIS*V_VIS : 0);
    end
  endtask

  task automatic test_reset_mid_flash();
    int whites;
    whites = 0;
    runTo(0, 0);
    runTo(3, 1);
    flash_req = 1'b1;
    applyStimulus();
    flash_req = 1'b0;
    runTo(0, 0);
    runTo(0, 0);
    runTo(10, 2);
    test_reset();
    for (int n = 0; n < 3*H_TOT*V_TOT; n++) begin
      layer_rgb_i = {$urandom, $urandom} & {NL{12'h7FF}};
      applyStimulus();
      if (exValid) begin
        checks++;
        if (rgb_o !== ex.rgb) begin
          fails++;
          $display("[TB] FAIL post_reset_pixel: at h=%0d v=%0d got %h expected %h", ex.hc, ex.vc, rgb_o, ex.rgb);
        end
        if (rgb_o === 12'hFFF) whites++;
      end
    end
    checks++;
    if (whites !== 0) begin
      fails++;
      $display("[TB] FAIL post_reset_flash: got %0d white pixels expected 0", whites);
    end
  endtask

  initial begin
    rst = 1'b1;
    flash_req = 1'b0;
    layer_rgb_i = '0;
    layer_opaque_i = '0;
    layer_en_i = '1;
    test_reset();
    test_delay();
    test_priority();
    test_blank();
    test_random_mix();
    test_shadow();
    test_flash();
    test_reset_mid_flash();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
